timer_irq_controller: RTL

//  Downstream of the timer: turns comparator_0_output / comparator_1_output
//  (level flags) into rising-edge events and latches them as pending bits.
//  It presents one unmasked pending source at a time to the CPU as irq + irq_id.
//  The source is held until irq_ack. Lost events (re-fire while still pending) are counted.

---
 rtl/timer_irq_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/timer_irq_controller.sv
// -----------------------------------------------------------------------------
// timer_irq_controller
//
// Sits downstream of the timer. Converts level-type comparator flags into
// rising-edge events, latches them as pending bits and offers one unmasked
// pending source at a time to the CPU as irq + irq_id. The request is held
// until the CPU acknowledges it, followed by a one-cycle gap with irq low.
// Events that re-fire while their source is still pending are lost; they are
// counted in a saturating counter.
//
// Ports
//   clk         single system clock, rising edge
//   rst         asynchronous, active-low reset
//   enable      1: capture new events; 0: capture suppressed
//   irq_src     level inputs (bit0 = comparator_0_output, bit1 = comparator_1_output)
//   mask_we     load mask from mask_data at the clock edge
//   mask_data   per-source enable, 1 = may raise irq
//   irq_ack     CPU acknowledge, one-cycle pulse
//   miss_clear  clear miss_count at the clock edge
//   irq         interrupt request to the CPU
//   irq_id      zero-extended index of the source being signalled
//   pending     latched event flags
//   mask        current mask register
//   miss_count  saturating count of lost events
// -----------------------------------------------------------------------------
module timer_irq_controller #(
  parameter int NUM_SOURCES    = 2,
  parameter int ID_WIDTH       = 1,
  parameter int MISS_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_SOURCES-1:0]    irq_src,
  input  logic                      mask_we,
  input  logic [NUM_SOURCES-1:0]    mask_data,
  input  logic                      irq_ack,
  input  logic                      miss_clear,
  output logic                      irq,
  output logic [ID_WIDTH-1:0]       irq_id,
  output logic [NUM_SOURCES-1:0]    pending,
  output logic [NUM_SOURCES-1:0]    mask,
  output logic [MISS_CNT_WIDTH-1:0] miss_count
);

  localparam int MIN_ID_WIDTH = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  if (NUM_SOURCES < 1) begin : g_bad_num_sources
    $error("timer_irq_controller: NUM_SOURCES must be at least 1");
  end
  if (ID_WIDTH < MIN_ID_WIDTH) begin : g_bad_id_width
    $error("timer_irq_controller: ID_WIDTH too narrow for NUM_SOURCES");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ID_WIDTH-1:0]      irq_id_nxt;

  logic [NUM_SOURCES-1:0]   src_q;
  logic [NUM_SOURCES-1:0]   src_event;
  logic [NUM_SOURCES-1:0]   ack_clear;
  logic [NUM_SOURCES-1:0]   pending_nxt;
  logic [NUM_SOURCES-1:0]   candidates;
  logic                     win_valid;
  logic [ID_WIDTH-1:0]      win_idx;
  logic                     miss_any;

  // ---------------------------------------------------------------------------
  // Edge detection and pending bookkeeping
  // ---------------------------------------------------------------------------

  // src_q tracks the raw level even while capture is disabled, so a level
  // that is already high when enable rises does not count as a new event.
  assign src_event = irq_src & ~src_q & {NUM_SOURCES{enable}};

  // Acknowledge clears only the bit currently being signalled.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    ack_clear = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      ack_clear[i] = (state == ST_ASSERT) && irq_ack && (irq_id == ID_WIDTH'(i));
    end
  end

  // A new event beats a same-edge clear, so the source is not lost.
  assign pending_nxt = (pending & ~ack_clear) | src_event;

  // A re-fire is lost only if the bit would have stayed set anyway.
  assign miss_any = |(src_event & pending & ~ack_clear);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      miss_count <= '0;
    end else begin
      // NOTE: registered state is always updated with non-blocking
      // assignments so every flop samples the pre-edge values.
      src_q   <= irq_src;
      pending <= pending_nxt;
      if (mask_we) begin
        mask <= mask_data;
      end
      if (miss_clear) begin
        miss_count <= '0;
      end else if (miss_any && (miss_count != '1)) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration: lowest-index unmasked pending source wins
  // ---------------------------------------------------------------------------
  assign candidates = pending & mask;
  assign win_valid  = |candidates;

  always_comb begin
    win_idx = '0;
    // Scan downwards so the last hit, i.e. the lowest index, is kept.
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        win_idx = ID_WIDTH'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_nxt;
      irq_id <= irq_id_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id;
    unique case (state)
      ST_IDLE: begin
        if (win_valid) begin
          irq_id_nxt = win_idx;
          state_nxt  = ST_ASSERT;
        end
      end
      // Once asserted, only an acknowledge withdraws the request; later mask
      // or enable changes are deliberately ignored.
      ST_ASSERT: begin
        if (irq_ack) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Decoded straight from the state flops, so reset drops irq without a clock.
  assign irq = (state == ST_ASSERT);

endmodule
